// File: rtl/ab_gain_ctrl.sv
// ab_gain_ctrl: frame-luminance gain controller with hysteresis stepping, manual override and valid/ready gain delivery
module ab_gain_ctrl #(
  parameter int          horizontal = 1920,
  parameter int          vertical   = 1080,
  parameter int          UPPER      = 1200,
  parameter int          LOWER      = 1100,
  parameter logic [12:0] max_Gain   = 13'h500,
  parameter logic [12:0] min_Gain   = 13'h040,
  parameter logic [12:0] INIT_GAIN  = 13'h200,
  parameter int          ADJUST     = 4,
  parameter int          SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        manual_mode,
  input  logic [12:0] manual_gain,
  input  logic        fv_in,
  input  logic        lv_in,
  input  logic [11:0] data_in,
  output logic [12:0] gain_out,
  output logic        gain_valid,
  input  logic        gain_ready,
  output logic [35:0] lum_sum,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ACCUM, EVAL, UPDATE, HOLD} state_e;
  localparam int HW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam logic [21:0] NPIX   = 22'(horizontal * vertical);
  localparam logic [35:0] THR_HI = 36'(longint'(horizontal) * longint'(vertical) * longint'(UPPER));
  localparam logic [35:0] THR_LO = 36'(longint'(horizontal) * longint'(vertical) * longint'(LOWER));
  state_e state_q, state_d;
  logic fv_q, rise, fall, pix, cnt_ok, hold_done;
  logic [35:0] acc_q, acc_d, lum_sum_q, lum_sum_d;
  logic [21:0] cnt_q, cnt_d;
  logic [12:0] gain_q, gain_d, target, dn;
  logic [13:0] up;
  logic frame_err_q, frame_err_d;
  logic [HW-1:0] hold_q, hold_d;
  assign rise      = fv_in & ~fv_q;
  assign fall      = ~fv_in & fv_q;
  assign pix       = fv_in & lv_in;
  assign cnt_ok    = cnt_q == NPIX;
  assign hold_done = 32'(hold_q) + 32'd1 == 32'(SETTLE);
  assign gain_out  = gain_q;
  assign lum_sum   = lum_sum_q;
  assign frame_err = frame_err_q;
  // State register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // Datapath registers; a reset abandons any pending handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      lum_sum_q   <= '0;
      gain_q      <= INIT_GAIN;
      frame_err_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      fv_q        <= fv_in;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      lum_sum_q   <= lum_sum_d;
      gain_q      <= gain_d;
      frame_err_q <= frame_err_d;
      hold_q      <= hold_d;
    end
  end
  // Candidate gain: steps are evaluated one bit wider so they never wrap before clamping
  always_comb begin
    dn     = gain_q - 13'(ADJUST);
    up     = {1'b0, gain_q} + 14'(ADJUST);
    target = manual_mode ? (manual_gain < min_Gain ? min_Gain : manual_gain > max_Gain ? max_Gain : manual_gain)
           : acc_q > THR_HI ? ({1'b0, gain_q} < 14'(min_Gain) + 14'(ADJUST) ? min_Gain : dn)
           : acc_q < THR_LO ? (up > {1'b0, max_Gain} ? max_Gain : up[12:0])
           : gain_q;
  end
  // Next-state logic; a rise outside IDLE is never captured, so that frame is skipped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise && enable) state_d = ACCUM;
      ACCUM:   if (fall) state_d = EVAL;
      EVAL:    state_d = cnt_ok && target != gain_q ? UPDATE : IDLE;
      UPDATE:  if (gain_ready) state_d = SETTLE > 0 ? HOLD : IDLE;
      HOLD:    if (fall && hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Accumulation, evaluation and settle counting; the first pixel may coincide with the frame rise
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    lum_sum_d   = lum_sum_q;
    gain_d      = gain_q;
    frame_err_d = 1'b0;
    hold_d      = hold_q;
    if (state_q == IDLE && rise && enable) begin
      acc_d = lv_in ? 36'(data_in) : '0;
      cnt_d = 22'(lv_in);
    end
    if (state_q == ACCUM && pix) begin
      acc_d = acc_q + 36'(data_in);
      cnt_d = &cnt_q ? cnt_q : cnt_q + 22'd1;
    end
    if (state_q == EVAL) begin
      lum_sum_d   = acc_q;
      frame_err_d = ~cnt_ok;
      gain_d      = cnt_ok ? target : gain_q;
    end
    if (state_q == UPDATE) hold_d = '0;
    if (state_q == HOLD && fall) hold_d = hold_done ? '0 : hold_q + HW'(1);
  end
  // Moore outputs
  always_comb begin
    gain_valid = state_q == UPDATE;
    busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_ab_gain_ctrl.sv
// tb_ab_gain_ctrl: scoreboard bench for ab_gain_ctrl on a 4x2 frame
module tb_ab_gain_ctrl;
  localparam int NP = 8, THI = NP * 1200, TLO = NP * 1100, GMAX = 'h500, GMIN = 'h40, ADJ = 4, SETTLE = 2;
  localparam int K_GAIN = 0, K_ERR = 1, K_QUIET = 2;
  typedef struct {int kind; logic [12:0] gain; logic [35:0] lum;} exp_t;
  logic clk = 0, rst, enable, manual_mode, fv_in, lv_in, gain_valid, gain_ready, frame_err, busy;
  logic [12:0] manual_gain, gain_out;
  logic [11:0] data_in;
  logic [35:0] lum_sum;
  int errors = 0, checks = 0;
  exp_t sb[$];
  logic [11:0] pxq[$];
  int m_gain = 'h200, m_skip = 0;
  ab_gain_ctrl #(.horizontal(4), .vertical(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .manual_mode(manual_mode), .manual_gain(manual_gain),
    .fv_in(fv_in), .lv_in(lv_in), .data_in(data_in), .gain_out(gain_out), .gain_valid(gain_valid),
    .gain_ready(gain_ready), .lum_sum(lum_sum), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: frame-level rules applied to the pixel list before it is driven
  task automatic model(input logic man, input logic [12:0] mg, input logic en);
    longint sum = 0;
    int t;
    exp_t e;
    foreach (pxq[i]) sum += pxq[i];
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (!en) return;
    e.lum = 36'(sum);
    if (pxq.size() != NP) begin
      e.kind = K_ERR; e.gain = 13'(m_gain);
      sb.push_back(e);
      return;
    end
    if (man) t = mg < GMIN ? GMIN : mg > GMAX ? GMAX : int'(mg);
    else if (sum > THI) t = m_gain - ADJ < GMIN ? GMIN : m_gain - ADJ;
    else if (sum < TLO) t = m_gain + ADJ > GMAX ? GMAX : m_gain + ADJ;
    else t = m_gain;
    e.kind = t != m_gain ? K_GAIN : K_QUIET;
    e.gain = 13'(t);
    sb.push_back(e);
    if (t != m_gain) begin
      m_gain = t;
      m_skip = SETTLE;
    end
  endtask
  // Drive pxq as one frame of 4-pixel lines; bp>0 delays gain_ready, bp<0 leaves it low and returns at the fall
  task automatic frame(input logic man, input logic [12:0] mg, input logic en, input int bp);
    bit first;
    model(man, mg, en);
    manual_mode = man; manual_gain = mg; enable = en;
    if (bp != 0) gain_ready = 0;
    first = $urandom_range(0, 3) == 0;
    @(posedge clk) #1;
    fv_in = 1; lv_in = first; data_in = first ? pxq[0] : 12'($urandom);
    for (int i = first ? 1 : 0; i < pxq.size(); i++) begin
      if (i > 0 && i % 4 == 0) begin
        @(posedge clk) #1;
        lv_in = 0; data_in = 12'($urandom);
      end
      @(posedge clk) #1;
      lv_in = 1; data_in = pxq[i];
    end
    @(posedge clk) #1 lv_in = 0;
    @(posedge clk) #1 fv_in = 0;
    if (bp < 0) return;
    repeat (bp) @(posedge clk);
    #1 gain_ready = 1;
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic cf(input int v, input int n, input logic man, input logic [12:0] mg, input logic en, input int bp);
    pxq.delete();
    for (int i = 0; i < n; i++) pxq.push_back(12'(v));
    frame(man, mg, en, bp);
  endtask
  // Monitor: pops the scoreboard on each observable DUT outcome
  logic prev_fv = 0, prev_valid = 0, prev_err = 0, prev_busy = 0, seen = 0;
  logic [12:0] held;
  int cyc = 0, fall_cyc = 0;
  task automatic pop(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected event kind=%0d gain=0x%0h lum=0x%0h at %0t", kind, gain_out, lum_sum, $time);
      return;
    end
    e = sb.pop_front();
    chk("event kind", 36'(kind), 36'(e.kind));
    chk("gain_out", 36'(gain_out), 36'(e.gain));
    chk("lum_sum", lum_sum, e.lum);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_valid = 0; prev_err = 0; prev_busy = 0; seen = 0;
    end else begin
      if (prev_fv && !fv_in) fall_cyc = cyc;
      if (busy && !prev_busy) seen = 0;
      if (gain_valid && !prev_valid) begin
        chk("valid latency after fall", 36'(cyc - fall_cyc), 36'd2);
        held = gain_out;
      end
      if (gain_valid && prev_valid) chk("gain_out stable", 36'(gain_out), 36'(held));
      if (prev_err) chk("frame_err one cycle", 36'(frame_err), 36'd0);
      if (frame_err) begin
        pop(K_ERR); seen = 1;
      end
      if (gain_valid && gain_ready) begin
        pop(K_GAIN); seen = 1;
      end
      if (prev_busy && !busy && !seen) begin
        pop(K_QUIET); seen = 1;
      end
      prev_valid = gain_valid; prev_err = frame_err; prev_busy = busy;
    end
    prev_fv = fv_in;
  end
  initial begin
    int k, kind, n, v;
    logic man, en;
    logic [12:0] mg;
    int bp;
    rst = 1; enable = 1; manual_mode = 0; manual_gain = 0; fv_in = 0; lv_in = 0; data_in = 0; gain_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gain_out", 36'(gain_out), 36'h200);
    chk("reset gain_valid", 36'(gain_valid), 36'd0);
    chk("reset lum_sum", lum_sum, 36'd0);
    chk("reset frame_err", 36'(frame_err), 36'd0);
    chk("reset busy", 36'(busy), 36'd0);
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    cf(100, 8, 0, 0, 1, 0);
    cf(1150, 8, 0, 0, 1, 0); cf(1150, 8, 0, 0, 1, 0);
    cf(100, 8, 0, 0, 1, 0);
    cf(1150, 8, 1, 13'h042, 1, 0);
    cf(1150, 8, 0, 0, 1, 0); cf(1150, 8, 0, 0, 1, 0);
    cf(4000, 8, 0, 0, 1, 0);
    cf(1150, 8, 0, 0, 1, 0); cf(1150, 8, 0, 0, 1, 0);
    cf(4000, 8, 0, 0, 1, 0);
    cf(4000, 7, 0, 0, 1, 0);
    cf(100, 9, 0, 0, 1, 0);
    cf(100, 8, 0, 0, 1, 20);
    cf(100, 8, 0, 0, 1, 0); cf(100, 8, 0, 0, 1, 0);
    cf(1150, 8, 1, 13'h1FFF, 1, 0);
    cf(1150, 8, 0, 0, 1, 0); cf(1150, 8, 0, 0, 1, 0);
    cf(1150, 8, 1, 13'h500, 1, 0);
    cf(100, 8, 0, 0, 0, 0);
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 4);
      n = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 7 : 9) : 8;
      v = kind == 0 ? $urandom_range(0, 1000) : kind == 1 ? $urandom_range(2000, 4095)
        : kind == 2 ? ($urandom_range(0, 1) ? 1100 : 1200) : ($urandom_range(0, 1) ? 1099 : 1201);
      pxq.delete();
      for (int i = 0; i < n; i++) pxq.push_back(kind == 3 ? 12'($urandom) : 12'(v));
      man = $urandom_range(0, 5) == 0;
      case ($urandom_range(0, 4))
        0: mg = 13'h0;
        1: mg = 13'h1FFF;
        2: mg = 13'(m_gain);
        3: mg = $urandom_range(0, 1) ? 13'h040 : 13'h500;
        default: mg = 13'($urandom);
      endcase
      en = $urandom_range(0, 9) != 0;
      bp = $urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : 0;
      frame(man, mg, en, bp);
    end
    repeat (30) @(posedge clk);
    #1;
    cf(1150, 8, 0, 0, 1, 0); cf(1150, 8, 0, 0, 1, 0); cf(1150, 8, 0, 0, 1, 0);
    cf(100, 8, 1, 13'h300, 1, -1);
    k = 0;
    while (!gain_valid && k < 10) begin
      @(posedge clk) #1;
      k++;
    end
    chk("gain_valid before reset", 36'(gain_valid), 36'd1);
    rst = 1; sb.delete();
    @(posedge clk) #1;
    chk("mid-reset gain_valid", 36'(gain_valid), 36'd0);
    chk("mid-reset gain_out", 36'(gain_out), 36'h200);
    chk("mid-reset busy", 36'(busy), 36'd0);
    rst = 0; gain_ready = 1; m_gain = 'h200; m_skip = 0;
    @(posedge clk) #1;
    cf(100, 8, 0, 0, 1, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard drained", 36'(sb.size()), 36'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ab_gain_ctrl.md
# ab_gain_ctrl

Frame-level gain controller for the auto-brightness datapath. It measures the luminance of each incoming frame from the pixel stream, compares the frame sum against hysteresis thresholds, and steps the 13-bit gain with saturation. It delivers each new gain to the gain/clip/shift pipeline through a valid/ready handshake, then holds for a settle period. It sits beside the gain pipeline and taps its fv/lv/data stream, replacing the inline gain-update logic with a sequenced, observable controller that supports manual override.

## Interface
- horizontal, 1920, active pixels per line
- vertical, 1080, active lines per frame
- UPPER, 1200, upper 12-bit average threshold
- LOWER, 1100, lower 12-bit average threshold (LOWER < UPPER)
- max_Gain, 13'h500, gain ceiling
- min_Gain, 13'h040, gain floor
- INIT_GAIN, 13'h200, reset gain (unity, since the datapath applies >>9)
- ADJUST, 4, gain step per decision
- SETTLE, 2, frames to skip after an applied gain change (0 allowed)

Ports (clock and reset first):
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- enable  in  1  auto/manual control enable; sampled in IDLE only
- manual_mode  in  1  1 = use manual_gain instead of auto stepping; sampled in EVAL
- manual_gain  in  13  requested manual gain
- fv_in  in  1  frame valid
- lv_in  in  1  line valid; pixel is valid when fv_in & lv_in
- data_in  in  12  pixel data
- gain_out  out  13  current or pending gain value
- gain_valid  out  1  new gain offered to the datapath
- gain_ready  in  1  datapath accepts gain
- lum_sum  out  36  last complete frame sum
- frame_err  out  1  one-cycle pulse: pixel count mismatch
- busy  out  1  state != IDLE

## Operation
- The block registers fv_in into fv_q.
  - rise = fv_in & ~fv_q
  - fall = ~fv_in & fv_q
- States: IDLE, ACCUM, EVAL, UPDATE, HOLD.
- IDLE
  - Transitions on rise & enable → ACCUM.
  - In the same cycle, acc <= lv_in ? data_in : 0 and cnt <= lv_in.
  - If fv_in is already high when IDLE is entered, the block waits for the next rise; that frame is skipped.
- ACCUM
  - Each cycle with fv_in & lv_in: acc += data_in (36-bit), cnt += 1 (22-bit, saturating).
  - On fall → EVAL.
- EVAL (one cycle)
  - lum_sum <= acc.
  - If cnt != horizontal*vertical: pulse frame_err, leave gain unchanged, → IDLE.
  - Otherwise compute target:
    - Manual: target = clamp(manual_gain, min_Gain, max_Gain).
    - Auto, acc > horizontal*vertical*UPPER: target = max(gain_out − ADJUST, min_Gain).
    - Auto, acc < horizontal*vertical*LOWER: target = min(gain_out + ADJUST, max_Gain).
    - Otherwise: target = gain_out.
  - If target != gain_out: gain_out <= target, → UPDATE. Else → IDLE.
- UPDATE
  - gain_valid = 1.
  - gain_out is held stable until gain_valid & gain_ready.
  - On acceptance → HOLD if SETTLE > 0, else IDLE.
  - Pixel traffic is ignored; no accumulation.
- HOLD
  - Counts fall events; after SETTLE falls → IDLE.
  - No accumulation.
- Arithmetic
  - The step is computed at 14 bits before clamping, so there is no wrap below 0 or above 13'h1FFF.
  - Thresholds are compile-time constants, at least 36 bits wide.
- enable deasserted outside IDLE does not abort the sequence; it takes effect on the next IDLE decision.
- Reset mid-operation
  - Next edge: state IDLE, gain_out = INIT_GAIN, gain_valid = 0.
  - A pending handshake is abandoned.

## Timing
- Reset values:
  - gain_out = INIT_GAIN, gain_valid = 0, lum_sum = 0, frame_err = 0, busy = 0.
  - acc = 0, cnt = 0, hold counter = 0.
- Fall is seen at cycle N (fv_in low, fv_q high).
  - ACCUM→EVAL at edge N+1.
  - lum_sum, gain_out and frame_err update at edge N+2.
  - gain_valid is high from N+2.
- Minimum handshake: gain_ready high at N+2 → accepted at edge N+3, gain_valid low from N+3.
- gain_valid stays high indefinitely while gain_ready = 0; gain_out is stable throughout.
- A rise that arrives while in EVAL, UPDATE or HOLD is not captured; that frame is skipped.

## Test plan
- Dark frame: horizontal=4, vertical=2, all pixels 100, gain 0x200 → gain_out 0x204, gain_valid high 2 cycles after fall, accepted with gain_ready=1, lum_sum=800.
- Bright frame: pixels 4000, gain at 0x042 → gain_out 0x040 (clamped); the next bright frame produces no UPDATE and the FSM returns to IDLE.
- Short frame: 7 valid pixels instead of 8 → frame_err is a 1-cycle pulse, gain_out unchanged, no gain_valid.
- Backpressure: gain_ready held 0 for 20 cycles → gain_valid and gain_out stable; acceptance occurs on the first ready cycle; with SETTLE=2, the next two frames are ignored.
- Manual mode: manual_mode=1, manual_gain=0x1FFF → gain_out 0x500; manual_gain=0x500 again → no UPDATE.
- Reset during UPDATE: assert rst while gain_valid=1 → next cycle gain_valid=0, gain_out=0x200, busy=0.
